// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 5-stage RV64 pipeline.
// Optional PIPE_CTRL_PERF_EN adds bubble/freeze performance counters.
module pipeline_ctrl #(
  parameter int RESET_HOLD  = 4,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_readMem,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_redirect,
  input  logic        imem_ready,
  input  logic        mem_req,
  input  logic        mem_ready,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_freeze_cnt,
`endif
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_pause,
  output logic        id_ex_flush,
  output logic        pipeline_en,
  output logic        mem_err
);

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  logic load_use;
  logic stall;
  logic frozen;
  logic held;

  assign load_use = ex_readMem && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign stall    = mem_req && !mem_ready;
  assign held     = rst || (state == HOLD);
  assign frozen   = !held &&
                    ((state == ERROR) ||
                     ((state == RUN) && stall) ||
                     ((state == MEM_WAIT) && !mem_ready));

  // Reset cycle already presents the reset values, before state settles.
  assign mem_err = err_q && !rst;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_pause = 1'b0;
    id_ex_flush = 1'b0;
    pipeline_en = 1'b1;
    if (held) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (frozen) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      pipeline_en = 1'b0;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_pause = 1'b1;
    end else if (!imem_ready) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HOLD;
      hold_cnt <= '0;
      tmo_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_cnt == HW'(RESET_HOLD - 1)) begin
            state    <= RUN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (stall) begin
            state   <= MEM_WAIT;
            tmo_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state   <= RUN;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TW'(MEM_TIMEOUT - 1)) begin
            state   <= ERROR;
            tmo_cnt <= TW'(MEM_TIMEOUT);
            err_q   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: state <= HOLD;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [1:0] bubble_inc;

  // A redirect throws away two fetched slots; a load-use inserts one.
  always_comb begin
    bubble_inc = 2'd0;
    if (!held && !frozen) begin
      if (ex_redirect)
        bubble_inc = 2'd2;
      else if (load_use)
        bubble_inc = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
      perf_freeze_cnt <= '0;
    end else begin
      perf_bubble_cnt <= perf_bubble_cnt + {30'd0, bubble_inc};
      if (frozen)
        perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues expected outputs,
// negedge monitor pops and compares.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_readMem;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       ex_redirect, imem_ready, mem_req, mem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_pause;
  logic       id_ex_flush, pipeline_en, mem_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_freeze_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .RESET_HOLD (4),
    .MEM_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_readMem (ex_readMem),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_redirect(ex_redirect),
    .imem_ready (imem_ready),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
`ifdef PIPE_CTRL_PERF_EN
    .perf_bubble_cnt(perf_bubble_cnt),
    .perf_freeze_cnt(perf_freeze_cnt),
`endif
    .pc_en      (pc_en),
    .if_id_en   (if_id_en),
    .if_id_flush(if_id_flush),
    .id_ex_pause(id_ex_pause),
    .id_ex_flush(id_ex_flush),
    .pipeline_en(pipeline_en),
    .mem_err    (mem_err)
  );

  // {pc_en, if_id_en, if_id_flush, id_ex_pause, id_ex_flush, pipeline_en, mem_err}
  localparam logic [6:0] E_HOLD = 7'b0010110;
  localparam logic [6:0] E_RUN  = 7'b1100010;
  localparam logic [6:0] E_LU   = 7'b0001010;
  localparam logic [6:0] E_RDIR = 7'b1110110;
  localparam logic [6:0] E_FW   = 7'b0110010;
  localparam logic [6:0] E_FRZ  = 7'b0000000;
  localparam logic [6:0] E_ERR  = 7'b0000001;

  typedef struct {
    logic [6:0] v;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input logic r, input logic rm, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic rdir, input logic imr,
                      input logic mrq, input logic mrd,
                      input logic [6:0] e, input string n);
    exp_t x;
    @(posedge clk);
    #1;
    rst         = r;
    ex_readMem  = rm;
    ex_rd       = rd;
    id_rs1      = rs1;
    id_rs2      = rs2;
    ex_redirect = rdir;
    imem_ready  = imr;
    mem_req     = mrq;
    mem_ready   = mrd;
    x.v         = e;
    x.name      = n;
    q.push_back(x);
  endtask

  task automatic idle(input logic [6:0] e, input string n);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e, n);
  endtask

  always @(negedge clk) begin
    exp_t       x;
    logic [6:0] act;
    if (q.size() > 0) begin
      x   = q.pop_front();
      act = {pc_en, if_id_en, if_id_flush, id_ex_pause,
             id_ex_flush, pipeline_en, mem_err};
      checks++;
      if (act !== x.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", x.name, act, x.v);
      end
    end
  end

  initial begin
    rst = 1'b1; ex_readMem = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    ex_redirect = 1'b0; imem_ready = 1'b1; mem_req = 1'b0; mem_ready = 1'b0;

    step(1'b1, 0, 0, 0, 0, 0, 1, 0, 0, E_HOLD, "reset0");
    step(1'b1, 0, 0, 0, 0, 0, 1, 0, 0, E_HOLD, "reset1");
    for (int i = 0; i < 4; i++) idle(E_HOLD, "hold");
    idle(E_RUN, "run_after_hold");
    idle(E_RUN, "run_idle");

    step(0, 1, 5'd5, 5'd1, 5'd5, 0, 1, 0, 0, E_LU, "lu_rs2");
    idle(E_RUN, "lu_release");
    step(0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, E_RUN, "lu_x0");
    step(0, 1, 5'd7, 5'd7, 5'd2, 0, 1, 0, 0, E_LU, "lu_rs1");
    step(0, 0, 5'd7, 5'd7, 5'd7, 0, 1, 0, 0, E_RUN, "no_load");
    step(0, 1, 5'd9, 5'd9, 5'd9, 1, 1, 0, 0, E_RDIR, "redir_over_lu");
    step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_RDIR, "redir_over_fw");

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FW, "fetch_wait1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FW, "fetch_wait2");
    idle(E_RUN, "fetch_resume");

    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ, "freeze");
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, E_RUN, "freeze_release");
    idle(E_RUN, "post_freeze");

    step(0, 1, 5'd3, 5'd3, 5'd0, 1, 1, 1, 0, E_FRZ, "freeze_hides_redir");
    step(0, 1, 5'd3, 5'd3, 5'd0, 1, 1, 0, 1, E_RDIR, "redir_on_release");
    step(0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 1, 0, E_FRZ, "freeze_hides_lu");
    step(0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 1, E_LU, "lu_on_release");
    idle(E_RUN, "run_again");

    for (int i = 0; i < 9; i++)
      step(0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ, "wait_pre_timeout");
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, E_ERR, "timeout_err");
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, E_ERR, "err_sticky_ready");
    idle(E_ERR, "err_sticky_idle");

    step(1'b1, 0, 0, 0, 0, 0, 1, 0, 0, E_HOLD, "reset_from_err");
    for (int i = 0; i < 4; i++) idle(E_HOLD, "hold2");
    idle(E_RUN, "run_after_hold2");

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller for the 5-stage RV64 pipeline. Generates the PC enable, IF/ID enable/flush, ID/EX pause/flush and global `pipeline_en` that sequence the stage registers. Handles load-use bubbles, EX-stage redirects, instruction-fetch wait and multi-cycle data-memory wait, with a timeout watchdog. Sits beside the stage registers in the core top; all decisions are combinational from stage fields plus a small registered FSM.

## Interface
Parameters:
- `RESET_HOLD`, 4: cycles after reset release before the PC may advance.
- `MEM_TIMEOUT`, 256: consecutive MEM_WAIT cycles before `mem_err` is raised.

Ports:
- `clk`, in, 1: sole clock; all state updates on posedge.
- `rst`, in, 1: reset, synchronous, active-high.
- `ex_readMem`, in, 1: instruction in EX is a load.
- `ex_rd`, in, 5: EX destination register.
- `id_rs1`, `id_rs2`, in, 5 each: ID source registers.
- `ex_redirect`, in, 1: branch taken or jump resolved in EX.
- `imem_ready`, in, 1: fetch data valid this cycle.
- `mem_req`, in, 1: MEM stage has a load/store in flight.
- `mem_ready`, in, 1: data memory completes this cycle.
- `pc_en`, out, 1: PC register load enable.
- `if_id_en`, out, 1: IF/ID load enable.
- `if_id_flush`, out, 1: IF/ID loads a bubble.
- `id_ex_pause`, out, 1: ID/EX loads a bubble (load-use).
- `id_ex_flush`, out, 1: ID/EX loads a bubble (redirect).
- `pipeline_en`, out, 1: global stage-register load enable.
- `mem_err`, out, 1: sticky watchdog error.

## Operation
- FSM states: HOLD, RUN, MEM_WAIT, ERROR. Reset enters HOLD with hold counter = 0.
- HOLD: `pipeline_en`=1, `pc_en`=0, `if_id_en`=0, `if_id_flush`=1, `id_ex_flush`=1; counter increments; after `RESET_HOLD` cycles -> RUN.
- RUN, evaluated in priority order:
  1. Freeze: `mem_req && !mem_ready` -> `pipeline_en`=0, `pc_en`=0, `if_id_en`=0, all flush/pause 0; next state MEM_WAIT.
  2. Redirect: `ex_redirect` -> `if_id_flush`=1, `id_ex_flush`=1, `pc_en`=1 (PC takes target); load-use suppressed.
  3. Load-use: `ex_readMem && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2)` -> `pc_en`=0, `if_id_en`=0, `id_ex_pause`=1.
  4. Fetch wait: `!imem_ready` -> `pc_en`=0, `if_id_flush`=1; ID/EX and later advance normally.
  5. Otherwise all enables 1, all flush/pause 0.
- MEM_WAIT: outputs as Freeze; timeout counter increments each cycle. `mem_ready`=1 -> outputs evaluated as RUN rule 2..5 that cycle, counter cleared, -> RUN. Counter reaching `MEM_TIMEOUT` -> ERROR, `mem_err`=1.
- ERROR: as Freeze, `mem_err`=1, held until `rst`.
- `ex_redirect` or load-use present during freeze is held by the frozen registers and acted on in the release cycle.

## Timing
- Reset values (cycle `rst`=1 and following HOLD): `pc_en`=0, `if_id_en`=0, `if_id_flush`=1, `id_ex_pause`=0, `id_ex_flush`=1, `pipeline_en`=1, `mem_err`=0.
- All outputs combinational, zero latency from inputs and current state; state, counters and `mem_err` registered.
- Load-use costs exactly one bubble; redirect costs two flushed slots; freeze length = cycles `mem_ready` low.
- `rst` mid-MEM_WAIT or in ERROR: next cycle HOLD, counters 0, `mem_err` 0.
- Timeout counter width `$clog2(MEM_TIMEOUT+1)`; no wrap, saturates at error.

## Configuration
- `PIPE_CTRL_PERF_EN`: defined -> adds 32-bit outputs `perf_bubble_cnt` (load-use + redirect slots) and `perf_freeze_cnt` (freeze cycles), cleared on `rst`, wrapping at 2^32. Undefined -> ports and counters absent; control behaviour identical.

## Test plan
- Reset, `RESET_HOLD`=4 -> `pc_en`=0 for 4 cycles after `rst` drops, then 1; flushes deasserted from cycle 5.
- `ex_readMem`=1, `ex_rd`=5, `id_rs2`=5 -> one cycle `id_ex_pause`=1, `pc_en`=0; `ex_rd`=0 same case -> no stall.
- `ex_redirect`=1 together with load-use match -> `if_id_flush`=`id_ex_flush`=1, `pc_en`=1, `id_ex_pause`=0.
- `mem_req`=1, `mem_ready` low 3 cycles -> `pipeline_en`=0 for exactly 3 cycles, back to 1 on `mem_ready` cycle.
- `MEM_TIMEOUT`=8, `mem_ready` never asserts -> `mem_err`=1 after 8 wait cycles, stays 1; `rst` clears.
- `imem_ready`=0 two cycles -> `pc_en`=0, `if_id_flush`=1 both cycles, `pipeline_en` stays 1.
